servo_bank: RTL
===============

Name: servo_bank

Overview:
- Parametrised multi-channel successor to the single-channel servo PWM driver.
- Drives N_CH hobby servos from one shared 1 MHz frame counter, all channels frame-aligned.
- Maps each channel's position value to a pulse width and applies a per-frame slew-rate limit so servos ramp smoothly rather than jump.
- Sits between the game/timer logic (position producers) and the servo pins.

Parameters:
- N_CH, 4, number of servo channels
- POS_W, 7, width of each position field
- POS_MAX, 60, position full-scale; larger inputs clamp to this
- FRAME_CYCLES, 20000, frame period in clk_1mhz cycles (20 ms)
- MIN_PULSE, 700, pulse width in cycles at position 0
- MAX_PULSE, 2300, pulse width in cycles at POS_MAX
- STEP_MAX, 40, maximum pulse-width change per frame per channel, in cycles
- Legal ranges:
  - 0 < MIN_PULSE < MAX_PULSE < FRAME_CYCLES
  - STEP_MAX ≥ 1
  - POS_MAX ≥ 1 and POS_MAX < 2^POS_W

Ports:
- clk_1mhz  in  1  1 MHz clock
- rst  in  1  reset, synchronous, active-high
- pos  in  N_CH*POS_W  packed positions; channel i occupies bits [i*POS_W +: POS_W]
- pos_valid  in  1  load strobe for pos into the shadow registers
- enable  in  N_CH  per-channel enable; a disabled channel targets center
- servo_out  out  N_CH  PWM outputs
- settled  out  N_CH  channel's current pulse equals its target
- frame_start  out  1  one-cycle pulse marking the first high cycle of each frame

Behaviour:
- Reset (synchronous, active-high). On the next clk_1mhz edge with rst=1:
  - frame_cnt=0, shadow_pos[i]=0
  - cur_pulse[i]=CENTER, where CENTER=(MIN_PULSE+MAX_PULSE)/2, truncated (1500 with defaults)
  - servo_out=0, settled=all 1, frame_start=0
  - Reset asserted mid-pulse forces servo_out low on that edge; no partial frame is completed.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - frame_last is the cycle in which frame_cnt=FRAME_CYCLES-1.
- Shadow load:
  - Any cycle with pos_valid=1 copies pos into shadow_pos.
  - Target update uses shadow_pos as it stood before the current edge. A pos_valid that coincides with frame_last therefore takes effect one frame later.
- Mapping (sub-module, combinational):
  - p = min(shadow_pos[i], POS_MAX)
  - tgt[i] = MIN_PULSE + (MAX_PULSE-MIN_PULSE)*p / POS_MAX, truncating division
  - If enable[i]=0 (sampled at frame_last), tgt[i]=CENTER.
  - Intermediate product width is sized for (MAX_PULSE-MIN_PULSE)*POS_MAX with no overflow.
- Slew update, at the frame_last edge only, all channels in parallel:
  - d = tgt[i] - cur_pulse[i]
  - If |d| ≤ STEP_MAX, cur_pulse[i] ← tgt[i]; otherwise cur_pulse[i] moves STEP_MAX toward tgt[i].
  - Same edge: settled[i] ← (new cur_pulse[i] == tgt[i]).
  - cur_pulse never leaves [MIN_PULSE, MAX_PULSE].
  - A target change in the opposite direction reverses the ramp on the next frame_last. No overshoot.
- PWM output:
  - servo_out[i] is registered: servo_out[i] ← (frame_cnt < cur_pulse[i]).
  - Exactly cur_pulse[i] consecutive high cycles per frame, starting one cycle after frame_cnt=0.
- frame_start:
  - Registered: frame_start ← (frame_cnt==0).
  - High in the same cycle that every non-idle servo_out first goes high.
- Pulse boundaries: a frame's high width always equals the cur_pulse value held at that frame's start. cur_pulse changes only at frame_last, never mid-pulse.

Decomposition:
- Package servo_pkg holds:
  - default timing constants: FRAME_CYCLES, MIN_PULSE, MAX_PULSE, STEP_MAX
  - a CENTER calculation function
  - a pulse-width type sized by clog2(FRAME_CYCLES)
- Sub-module servo_pulse_map: clamp, scale and enable-select for one channel. Instantiated N_CH times in a generate loop.
- Frame counter, shadow registers, slew logic and output registers stay in servo_bank.

Test Plan:
- Reset release, enable=0, FRAME_CYCLES=3000 override → every frame, each servo_out high exactly 1500 cycles; frame_start coincides with the first high cycle; settled=all 1.
- enable[0]=1, pos ch0=60 with pos_valid → ch0 width 1540, 1580, …, reaching 2300 at the 20th frame; settled[0] goes 0 at the first update and 1 at the 20th.
- pos ch1=30, then 45, then 100, each fully settled → widths 1500, 1900, 2300 (clamped).
- pos_valid asserted exactly on frame_last with ch2: 60→0 → that frame_last edge still steps toward 2300; the following frame_last steps toward 700.
- ch0 ramping up at 1900, enable[0] dropped → width steps 1860, 1820, …, settling at 1500; other channels unaffected.
- rst asserted at frame_cnt=800 with servo_out high → servo_out=0 next edge; after release, widths return to 1500 and the frame restarts at count 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared timing defaults and types for the multi-channel servo driver.
package servo_pkg;

    localparam int DEF_FRAME_CYCLES = 20000;
    localparam int DEF_MIN_PULSE    = 700;
    localparam int DEF_MAX_PULSE    = 2300;
    localparam int DEF_STEP_MAX     = 40;

    // Wide enough to hold any frame count, so every pulse width fits as well
    localparam int PULSE_W = $clog2(DEF_FRAME_CYCLES);
    typedef logic [PULSE_W-1:0] pulse_t;

    function automatic int center_f(input int min_p, input int max_p);
        return (min_p + max_p) / 2;
    endfunction

endpackage

// File: rtl/servo_pulse_map.sv
// Per-channel position-to-pulse-width mapping: clamp, linear scale, enable select.
module servo_pulse_map
    import servo_pkg::*;
#(
    parameter int POS_W     = 7,
    parameter int POS_MAX   = 60,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int MAX_PULSE = DEF_MAX_PULSE
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic             enable_i,
    output pulse_t           tgt_o
);

    localparam int     SPAN     = MAX_PULSE - MIN_PULSE;
    localparam int     PROD_W   = $clog2(SPAN * POS_MAX + 1);
    localparam pulse_t CENTER_P = pulse_t'(center_f(MIN_PULSE, MAX_PULSE));

    logic [POS_W-1:0]  pos_clamp_s;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] quot_s;

    // Clamp, scale with a product wide enough for full-scale, then select center when disabled
    always_comb begin
        pos_clamp_s = pos_i;
        if (pos_i > POS_W'(POS_MAX)) begin
            pos_clamp_s = POS_W'(POS_MAX);
        end else begin
            pos_clamp_s = pos_i;
        end
        prod_s = PROD_W'(SPAN) * PROD_W'(pos_clamp_s);
        quot_s = prod_s / PROD_W'(POS_MAX);
        if (enable_i) begin
            tgt_o = pulse_t'(MIN_PULSE) + pulse_t'(quot_s);
        end else begin
            tgt_o = CENTER_P;
        end
    end

endmodule

// File: rtl/servo_bank.sv
// Frame-aligned N-channel servo PWM generator with per-frame slew limiting.
module servo_bank
    import servo_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int POS_W        = 7,
    parameter int POS_MAX      = 60,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int MIN_PULSE    = DEF_MIN_PULSE,
    parameter int MAX_PULSE    = DEF_MAX_PULSE,
    parameter int STEP_MAX     = DEF_STEP_MAX
) (
    input  logic                  clk_1mhz,
    input  logic                  rst,
    input  logic [N_CH*POS_W-1:0] pos,
    input  logic                  pos_valid,
    input  logic [N_CH-1:0]       enable,
    output logic [N_CH-1:0]       servo_out,
    output logic [N_CH-1:0]       settled,
    output logic                  frame_start
);

    localparam pulse_t CENTER_P = pulse_t'(center_f(MIN_PULSE, MAX_PULSE));
    localparam pulse_t STEP_P   = pulse_t'(STEP_MAX);
    localparam pulse_t LAST_P   = pulse_t'(FRAME_CYCLES - 1);

    pulse_t                  frame_cnt_q, frame_cnt_d;
    logic                    frame_last_s;
    logic [N_CH*POS_W-1:0]   shadow_q, shadow_d;
    pulse_t [N_CH-1:0]       cur_q, cur_d, tgt_s;
    logic [N_CH-1:0]         settled_q, settled_d;
    logic [N_CH-1:0]         servo_out_q, servo_out_d;
    logic                    frame_start_q, frame_start_d;

    // Targets come from the shadow as it stood before this edge
    for (genvar g = 0; g < N_CH; g++) begin : g_map
        servo_pulse_map #(
            .POS_W     (POS_W),
            .POS_MAX   (POS_MAX),
            .MIN_PULSE (MIN_PULSE),
            .MAX_PULSE (MAX_PULSE)
        ) u_map (
            .pos_i    (shadow_q[g*POS_W +: POS_W]),
            .enable_i (enable[g]),
            .tgt_o    (tgt_s[g])
        );
    end

    // Frame counter, shadow capture and PWM compare
    always_comb begin
        frame_last_s = (frame_cnt_q == LAST_P);
        if (frame_last_s) begin
            frame_cnt_d = pulse_t'(0);
        end else begin
            frame_cnt_d = frame_cnt_q + pulse_t'(1);
        end
        if (pos_valid) begin
            shadow_d = pos;
        end else begin
            shadow_d = shadow_q;
        end
        frame_start_d = (frame_cnt_q == pulse_t'(0));
        for (int i = 0; i < N_CH; i++) begin
            servo_out_d[i] = (frame_cnt_q < cur_q[i]);
        end
    end

    // Slew-limited pulse update; only moves at the frame boundary so no pulse is cut short
    always_comb begin
        cur_d     = cur_q;
        settled_d = settled_q;
        if (frame_last_s) begin
            for (int i = 0; i < N_CH; i++) begin
                if (tgt_s[i] > cur_q[i]) begin
                    if ((tgt_s[i] - cur_q[i]) <= STEP_P) begin
                        cur_d[i] = tgt_s[i];
                    end else begin
                        cur_d[i] = cur_q[i] + STEP_P;
                    end
                end else begin
                    if ((cur_q[i] - tgt_s[i]) <= STEP_P) begin
                        cur_d[i] = tgt_s[i];
                    end else begin
                        cur_d[i] = cur_q[i] - STEP_P;
                    end
                end
                settled_d[i] = (cur_d[i] == tgt_s[i]);
            end
        end else begin
            cur_d     = cur_q;
            settled_d = settled_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            frame_cnt_q   <= pulse_t'(0);
            shadow_q      <= '0;
            cur_q         <= {N_CH{CENTER_P}};
            settled_q     <= '1;
            servo_out_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            shadow_q      <= shadow_d;
            cur_q         <= cur_d;
            settled_q     <= settled_d;
            servo_out_q   <= servo_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign servo_out   = servo_out_q;
    assign settled     = settled_q;
    assign frame_start = frame_start_q;

endmodule
